// File: rtl/paint_scheduler.sv
// paint_scheduler: shares one circle painter between N_REQ brush sources.
// Each source owns a one-deep request slot; full slots are issued one at a
// time in round-robin order whenever the painter reports ready, and each
// source receives a one-cycle done pulse when its circle has been painted.
// Build macro PAINT_SCHED_PRIORITY_EN: source 0 always wins when its slot is
// full, and sources 1..N_REQ-1 stay round-robin among themselves.

module paint_scheduler #(
   parameter int N_REQ        = 4,
   parameter int MAX_RADIUS   = 64,
   parameter int WAIT_TIMEOUT = 4,
   localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [N_REQ-1:0]       req_valid_in,
   output logic [N_REQ-1:0]       req_ready_out,
   input  logic [11*N_REQ-1:0]    req_hcount_in,
   input  logic [10*N_REQ-1:0]    req_vcount_in,
   input  logic [17*N_REQ-1:0]    req_radius_in,
   input  logic                   painter_ready_in,
   output logic                   data_valid_out,
   output logic [10:0]            hcount_out,
   output logic [9:0]             vcount_out,
   output logic [16:0]            radius_out,
   output logic [GW-1:0]          grant_id_out,
   output logic [N_REQ-1:0]       done_out,
   output logic                   busy_out,
   output logic                   timeout_err_out
);

`ifdef PAINT_SCHED_PRIORITY_EN
   localparam bit PRIORITY_EN = 1'b1;
`else
   localparam bit PRIORITY_EN = 1'b0;
`endif

   localparam int             CW    = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [16:0]    MAX_R = 17'(MAX_RADIUS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOW  = 2'd1,
      WAIT_HIGH = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      wait_cnt;
   logic [CW-1:0]      wait_cnt_next;

   logic [N_REQ-1:0]   slot_full;
   logic [10:0]        slot_x [N_REQ];
   logic [9:0]         slot_y [N_REQ];
   logic [16:0]        slot_r [N_REQ];

   logic [GW-1:0]      rr_ptr;
   logic [GW-1:0]      winner;
   logic [GW-1:0]      cand;
   logic               found;

   logic               issue_en;
   logic               finish_en;
   logic               timeout_hit;

   function automatic logic [16:0] clamp_radius(input logic [16:0] r);
      return (r > MAX_R) ? MAX_R : r;
   endfunction

   // A slot is free exactly when it is not holding a pending stroke.
   assign req_ready_out = ~slot_full;

   // Pick the first full slot after the last winner, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      if (PRIORITY_EN && slot_full[0]) begin
         found  = 1'b1;
         winner = '0;
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && slot_full[cand] && !(PRIORITY_EN && cand == '0)) begin
               found  = 1'b1;
               winner = cand;
            end
         end
      end
   end

   // Next-state logic: issue from IDLE, then track the painter's ready low/high.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      issue_en      = 1'b0;
      finish_en     = 1'b0;
      timeout_hit   = 1'b0;
      case (state)
         IDLE: begin
            wait_cnt_next = '0;
            if (painter_ready_in && found) begin
               issue_en   = 1'b1;
               state_next = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!painter_ready_in) begin
               wait_cnt_next = '0;
               state_next    = WAIT_HIGH;
            end else if (wait_cnt == CW'(WAIT_TIMEOUT - 1)) begin
               wait_cnt_next = '0;
               timeout_hit   = 1'b1;
               finish_en     = 1'b1;
               state_next    = IDLE;
            end else begin
               wait_cnt_next = wait_cnt + CW'(1);
            end
         end
         WAIT_HIGH: begin
            if (painter_ready_in) begin
               finish_en  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register and the ready-drop watchdog counter.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Request slots: latch a stroke when free, release it when issued.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         slot_full <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            slot_x[i] <= '0;
            slot_y[i] <= '0;
            slot_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid_in[i] && !slot_full[i]) begin
               slot_full[i] <= 1'b1;
               slot_x[i]    <= req_hcount_in[11*i +: 11];
               slot_y[i]    <= req_vcount_in[10*i +: 10];
               slot_r[i]    <= clamp_radius(req_radius_in[17*i +: 17]);
            end
         end
         if (issue_en) begin
            slot_full[winner] <= 1'b0;
         end
      end
   end

   // Painter-facing outputs, arbitration pointer and completion signalling.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         data_valid_out  <= 1'b0;
         hcount_out      <= '0;
         vcount_out      <= '0;
         radius_out      <= '0;
         grant_id_out    <= '0;
         rr_ptr          <= GW'(N_REQ - 1);
         busy_out        <= 1'b0;
         done_out        <= '0;
         timeout_err_out <= 1'b0;
      end else begin
         data_valid_out <= issue_en;
         done_out       <= '0;
         if (issue_en) begin
            hcount_out   <= slot_x[winner];
            vcount_out   <= slot_y[winner];
            radius_out   <= slot_r[winner];
            grant_id_out <= winner;
            busy_out     <= 1'b1;
            if (!(PRIORITY_EN && winner == '0)) begin
               rr_ptr <= winner;
            end
         end
         if (finish_en) begin
            done_out[grant_id_out] <= 1'b1;
            busy_out               <= 1'b0;
         end
         if (timeout_hit) begin
            timeout_err_out <= 1'b1;
         end
      end
   end

endmodule
